// File: rtl/dsi_pkt_pkg.sv
// Shared types and constants for the DSI pixel packetizer.
// Defining DSI_ECC_EN enables the Hamming ECC helper used in packet headers.
package dsi_pkt_pkg;

    localparam logic [7:0] DT_VSS           = 8'h01;
    localparam logic [7:0] DT_VSE           = 8'h11;
    localparam logic [7:0] DT_HSS           = 8'h21;
    localparam logic [7:0] DT_HSE           = 8'h31;
    localparam logic [7:0] DT_PIXEL_DEFAULT = 8'h3E;

    typedef enum logic [1:0] {
        KIND_SHORT = 2'd0,
        KIND_PIX   = 2'd1
    } entry_kind_t;

    // Kind sits in the MSBs so the FIFO can expose it as a peek tag.
    typedef struct packed {
        entry_kind_t kind;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHORT   = 3'd1,
        ST_LHDR    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_FOOTER  = 3'd4
    } pkt_state_t;

`ifdef DSI_ECC_EN
    // Each mask selects the header bits that feed one parity bit P0..P5.
    function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
        logic [7:0] e;
        e    = '0;
        e[0] = ^(d & 24'hF12CB7);
        e[1] = ^(d & 24'hF2555B);
        e[2] = ^(d & 24'h749A6D);
        e[3] = ^(d & 24'hB8E38E);
        e[4] = ^(d & 24'hDF03F0);
        e[5] = ^(d & 24'hEFFC00);
        return e;
    endfunction
`endif

endpackage

// File: rtl/dsi_sync_fifo.sv
// Synchronous FIFO with a head read port and a tag peek of the entry behind the head.
module dsi_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [TAG_W-1:0] next_tag,
    output logic             full,
    output logic             empty,
    output logic             has_next
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign has_next   = (count > (AW+1)'(1));
    assign do_wr      = wr_en && !full;
    assign do_rd      = rd_en && !empty;
    assign rd_ptr_nxt = rd_ptr + 1'b1;
    assign rd_data    = mem[rd_ptr];
    assign next_tag   = mem[rd_ptr_nxt][WIDTH-1 -: TAG_W];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dsi_pixel_packetizer.sv
// Turns pixel-bus syncs and pixels into DSI short/long packet words with ready/valid output.
// Defining DSI_ECC_EN fills the header ECC byte; otherwise it is zero.
module dsi_pixel_packetizer
    import dsi_pkt_pkg::*;
#(
    parameter int         H_ACTIVE   = 640,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] DT_PIXEL   = DT_PIXEL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        dvalid,
    input  logic [31:0] pixel_data,
    input  logic        pkt_ready,
    output logic        pkt_valid,
    output logic [31:0] pkt_data,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic        ovf_err
);

    localparam logic [15:0] WC        = 16'(H_ACTIVE * 4);
    localparam logic [15:0] LAST_BEAT = 16'(H_ACTIVE - 1);

    logic        hs_s, vs_s, dv_s, hs_p, vs_p;
    logic [31:0] pd_s;
    logic        vs_rise, vs_fall, hs_rise, hs_fall;
    logic [4:0]  ev;
    logic        collision;
    logic        wr_req;
    entry_t      wr_entry;
    logic [33:0] fifo_rd;
    entry_t      head;
    logic [1:0]  next_tag;
    logic        fifo_full, fifo_empty, has_next;
    logic        pop, xfer;
    pkt_state_t  state;
    logic [15:0] beat_cnt;
    logic [23:0] hdr24;
    logic [7:0]  hdr_ecc;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s <= 1'b0;
            vs_s <= 1'b0;
            dv_s <= 1'b0;
            pd_s <= '0;
            hs_p <= 1'b0;
            vs_p <= 1'b0;
        end else begin
            hs_s <= hsync;
            vs_s <= vsync;
            dv_s <= dvalid;
            pd_s <= pixel_data;
            hs_p <= hs_s;
            vs_p <= vs_s;
        end
    end

    assign vs_rise   = vs_s & ~vs_p;
    assign vs_fall   = ~vs_s & vs_p;
    assign hs_rise   = hs_s & ~hs_p;
    assign hs_fall   = ~hs_s & hs_p;
    assign ev        = {vs_rise, vs_fall, hs_rise, hs_fall, dv_s};
    assign collision = |(ev & (ev - 5'd1));
    assign wr_req    = |ev;

    // Only the highest-priority event of a cycle is queued.
    always_comb begin
        wr_entry = '0;
        if (vs_rise) begin
            wr_entry.kind = KIND_SHORT;
            wr_entry.data = {24'h0, DT_VSS};
        end else if (vs_fall) begin
            wr_entry.kind = KIND_SHORT;
            wr_entry.data = {24'h0, DT_VSE};
        end else if (hs_rise) begin
            wr_entry.kind = KIND_SHORT;
            wr_entry.data = {24'h0, DT_HSS};
        end else if (hs_fall) begin
            wr_entry.kind = KIND_SHORT;
            wr_entry.data = {24'h0, DT_HSE};
        end else if (dv_s) begin
            wr_entry.kind = KIND_PIX;
            wr_entry.data = pd_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
        end else if (collision || (wr_req && fifo_full)) begin
            ovf_err <= 1'b1;
        end
    end

    dsi_sync_fifo #(
        .WIDTH (34),
        .DEPTH (FIFO_DEPTH),
        .TAG_W (2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_req),
        .wr_data  (wr_entry),
        .rd_en    (pop),
        .rd_data  (fifo_rd),
        .next_tag (next_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .has_next (has_next)
    );

    assign head  = entry_t'(fifo_rd);
    assign hdr24 = (state == ST_LHDR) ? {WC, DT_PIXEL} : head.data[23:0];

`ifdef DSI_ECC_EN
    assign hdr_ecc = dsi_ecc(hdr24);
`else
    assign hdr_ecc = 8'h00;
`endif

    // Outputs come straight from state and FIFO head, which only moves on a transfer.
    always_comb begin
        pkt_valid = 1'b0;
        pkt_data  = '0;
        pkt_sop   = 1'b0;
        pkt_eop   = 1'b0;
        case (state)
            ST_SHORT: begin
                pkt_valid = 1'b1;
                pkt_data  = {hdr_ecc, hdr24};
                pkt_sop   = 1'b1;
                pkt_eop   = 1'b1;
            end
            ST_LHDR: begin
                pkt_valid = 1'b1;
                pkt_data  = {hdr_ecc, hdr24};
                pkt_sop   = 1'b1;
            end
            ST_PAYLOAD: begin
                if (!fifo_empty && head.kind == KIND_PIX) begin
                    pkt_valid = 1'b1;
                    pkt_data  = head.data;
                end
            end
            ST_FOOTER: begin
                pkt_valid = 1'b1;
                pkt_eop   = 1'b1;
            end
            default: begin
                pkt_valid = 1'b0;
            end
        endcase
    end

    assign xfer = pkt_valid & pkt_ready;
    assign pop  = xfer & ((state == ST_SHORT) | (state == ST_PAYLOAD));

    function automatic pkt_state_t dispatch(input entry_kind_t k);
        return (k == KIND_PIX) ? ST_LHDR : ST_SHORT;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= dispatch(head.kind);
                    end
                end
                ST_SHORT: begin
                    if (xfer) begin
                        state <= has_next ? dispatch(entry_kind_t'(next_tag)) : ST_IDLE;
                    end
                end
                ST_LHDR: begin
                    if (xfer) begin
                        state    <= ST_PAYLOAD;
                        beat_cnt <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 16'd1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= ST_FOOTER;
                        end
                    end
                end
                ST_FOOTER: begin
                    if (xfer) begin
                        state <= fifo_empty ? ST_IDLE : dispatch(head.kind);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsi_pixel_packetizer.sv
// Scoreboard bench for dsi_pixel_packetizer: table-driven sync/line vectors plus
// hand-written backpressure, overflow, collision and mid-packet reset sequences.
module tb_dsi_pixel_packetizer;

    localparam int H_ACTIVE   = 4;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync, vsync, dvalid;
    logic [31:0] pixel_data;
    logic        pkt_ready;
    logic        pkt_valid;
    logic [31:0] pkt_data;
    logic        pkt_sop, pkt_eop;
    logic        ovf_err;

    typedef struct {
        logic        vs;
        logic        hs;
        logic        dv;
        logic [31:0] pix;
        int          n_exp;
        logic [33:0] e0;
        logic [33:0] e1;
    } vec_t;

    vec_t        tbl [14];
    logic [33:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    logic        toggle_ready = 1'b0;
    logic        have_hold = 1'b0;
    logic [33:0] hold_word;

    always #5 clk = ~clk;

    dsi_pixel_packetizer #(
        .H_ACTIVE   (H_ACTIVE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DT_PIXEL   (8'h3E)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hsync      (hsync),
        .vsync      (vsync),
        .dvalid     (dvalid),
        .pixel_data (pixel_data),
        .pkt_ready  (pkt_ready),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .pkt_sop    (pkt_sop),
        .pkt_eop    (pkt_eop),
        .ovf_err    (ovf_err)
    );

    function automatic logic [33:0] w(input logic [31:0] d, input logic s, input logic e);
        return {d, s, e};
    endfunction

    function automatic vec_t mk(input logic vs, input logic hs, input logic dv,
                                input logic [31:0] pix, input int n,
                                input logic [33:0] e0, input logic [33:0] e1);
        vec_t v;
        v.vs = vs; v.hs = hs; v.dv = dv; v.pix = pix;
        v.n_exp = n; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_ready) pkt_ready = ~pkt_ready;
    endtask

    task automatic applyStimulus(input vec_t v);
        tick();
        vsync      = v.vs;
        hsync      = v.hs;
        dvalid     = v.dv;
        pixel_data = v.pix;
        if (v.n_exp > 0) exp_q.push_back(v.e0);
        if (v.n_exp > 1) exp_q.push_back(v.e1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(mk(0, 0, 0, 32'h0, 0, '0, '0));
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pkt_valid) && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, 34'(exp_q.size()), 34'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: compares each transferred word and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            have_hold = 1'b0;
        end else begin
            if (have_hold) begin
                checkOutput("stall_hold", {pkt_valid, pkt_data, pkt_sop, pkt_eop}, {1'b1, hold_word});
            end
            if (pkt_valid && pkt_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", {pkt_data, pkt_sop, pkt_eop}, 34'h0);
                    checkOutput("unexpected_xfer", 34'd1, 34'd0);
                end else begin
                    checkOutput("pkt_word", {pkt_data, pkt_sop, pkt_eop}, exp_q.pop_front());
                end
                have_hold = 1'b0;
            end else if (pkt_valid) begin
                have_hold = 1'b1;
                hold_word = {pkt_data, pkt_sop, pkt_eop};
            end else begin
                have_hold = 1'b0;
            end
        end
    end

    initial begin
        int n;
        tbl[0]  = mk(1, 0, 0, 32'h0,  1, w(32'h0000_0001, 1, 1), '0);
        tbl[1]  = mk(1, 0, 0, 32'h0,  0, '0, '0);
        tbl[2]  = mk(0, 0, 0, 32'h0,  1, w(32'h0000_0011, 1, 1), '0);
        tbl[3]  = mk(0, 0, 0, 32'h0,  0, '0, '0);
        tbl[4]  = mk(0, 1, 0, 32'h0,  1, w(32'h0000_0021, 1, 1), '0);
        tbl[5]  = mk(0, 1, 0, 32'h0,  0, '0, '0);
        tbl[6]  = mk(0, 0, 0, 32'h0,  1, w(32'h0000_0031, 1, 1), '0);
        tbl[7]  = mk(0, 0, 0, 32'h0,  0, '0, '0);
        tbl[8]  = mk(0, 0, 0, 32'h0,  0, '0, '0);
        tbl[9]  = mk(0, 0, 1, 32'hA0, 2, w(32'h0000_103E, 1, 0), w(32'hA0, 0, 0));
        tbl[10] = mk(0, 0, 1, 32'hA1, 1, w(32'hA1, 0, 0), '0);
        tbl[11] = mk(0, 0, 1, 32'hA2, 1, w(32'hA2, 0, 0), '0);
        tbl[12] = mk(0, 0, 1, 32'hA3, 2, w(32'hA3, 0, 0), w(32'h0, 0, 1));
        tbl[13] = mk(0, 0, 0, 32'h0,  0, '0, '0);

        rst = 1'b1; hsync = 0; vsync = 0; dvalid = 0; pixel_data = '0; pkt_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 34'(pkt_valid), 34'd0);
        checkOutput("rst_sop",   34'(pkt_sop),   34'd0);
        checkOutput("rst_eop",   34'(pkt_eop),   34'd0);
        checkOutput("rst_data",  34'(pkt_data),  34'd0);
        checkOutput("rst_ovf",   34'(ovf_err),   34'd0);
        tick();
        rst = 1'b0;

        $display("[TB] sync and line vectors, pkt_ready held high");
        for (int i = 0; i < 14; i++) applyStimulus(tbl[i]);
        waitDrain("drain_line", 100);

        $display("[TB] line vectors with pkt_ready toggling");
        toggle_ready = 1'b1;
        for (int i = 4; i < 14; i++) applyStimulus(tbl[i]);
        waitDrain("drain_bp", 200);
        toggle_ready = 1'b0;
        tick();
        pkt_ready = 1'b1;
        @(negedge clk);
        checkOutput("no_ovf_after_lines", 34'(ovf_err), 34'd0);

        $display("[TB] overflow with pkt_ready low");
        tick();
        pkt_ready = 1'b0;
        applyStimulus(mk(0, 0, 1, 32'hB0, 2, w(32'h0000_103E, 1, 0), w(32'hB0, 0, 0)));
        applyStimulus(mk(0, 0, 1, 32'hB1, 1, w(32'hB1, 0, 0), '0));
        applyStimulus(mk(0, 0, 1, 32'hB2, 1, w(32'hB2, 0, 0), '0));
        applyStimulus(mk(0, 0, 1, 32'hB3, 2, w(32'hB3, 0, 0), w(32'h0, 0, 1)));
        applyStimulus(mk(0, 0, 1, 32'hB4, 0, '0, '0));
        applyStimulus(mk(0, 0, 1, 32'hB5, 0, '0, '0));
        idle(3);
        @(negedge clk);
        checkOutput("ovf_set", 34'(ovf_err), 34'd1);
        tick();
        pkt_ready = 1'b1;
        waitDrain("drain_ovf", 100);

        $display("[TB] vsync/hsync collision");
        do_reset();
        @(negedge clk);
        checkOutput("ovf_cleared", 34'(ovf_err), 34'd0);
        applyStimulus(mk(1, 1, 0, 32'h0, 1, w(32'h0000_0001, 1, 1), '0));
        idle(0);
        applyStimulus(mk(1, 1, 0, 32'h0, 0, '0, '0));
        applyStimulus(mk(1, 1, 0, 32'h0, 0, '0, '0));
        waitDrain("drain_coll_rise", 100);
        @(negedge clk);
        checkOutput("ovf_collision", 34'(ovf_err), 34'd1);
        applyStimulus(mk(0, 0, 0, 32'h0, 1, w(32'h0000_0011, 1, 1), '0));
        idle(2);
        waitDrain("drain_coll_fall", 100);

        $display("[TB] reset during payload");
        tick();
        pkt_ready = 1'b0;
        applyStimulus(mk(0, 0, 1, 32'hC0, 1, w(32'h0000_103E, 1, 0), '0));
        applyStimulus(mk(0, 0, 1, 32'hC1, 0, '0, '0));
        applyStimulus(mk(0, 0, 1, 32'hC2, 0, '0, '0));
        applyStimulus(mk(0, 0, 1, 32'hC3, 0, '0, '0));
        idle(1);
        n = 0;
        while (!(pkt_valid && pkt_sop) && n < 50) begin
            tick();
            n++;
        end
        checkOutput("hdr_wait", 34'(n < 50), 34'd1);
        tick();
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        @(negedge clk);
        checkOutput("payload_word", {1'b0, pkt_valid, pkt_data}, {2'b01, 32'hC0});
        do_reset();
        pkt_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_valid", 34'(pkt_valid), 34'd0);
        checkOutput("rst_mid_ovf",   34'(ovf_err),   34'd0);
        repeat (10) tick();
        @(negedge clk);
        checkOutput("fifo_empty_after_rst", 34'(pkt_valid), 34'd0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
